// File: rtl/instr_sequencer_if.sv
// Instruction sequencer bus: upstream instruction handshake, decoder strobe,
// execution-unit completion and status/event outputs.
interface instr_sequencer_if;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic        dec_enable;
    logic [3:0]  dec_opcode;
    logic        unit_done;
    logic        busy;
    logic        retire;
    logic        illegal;
    logic        timeout;
    logic [15:0] retire_count;

    // Sequencer side
    modport slave (
        input  instr_valid, instr, unit_done,
        output instr_ready, dec_enable, dec_opcode, busy,
               retire, illegal, timeout, retire_count
    );

    // Upstream / environment side
    modport master (
        output instr_valid, instr, unit_done,
        input  instr_ready, dec_enable, dec_opcode, busy,
               retire, illegal, timeout, retire_count
    );
endinterface

// File: rtl/instr_sequencer.sv
// Instruction sequencer: accepts one instruction at a time, strobes the
// decoder, waits for the execution unit with a bounded timeout, and
// reports retire / illegal / timeout events. All outputs are Moore.
module instr_sequencer #(
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    instr_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RETIRE} state_t;

    // Counter value on the final permitted WAIT cycle (counter starts at 0)
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [3:0]  opcode_q, opcode_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [15:0] retire_cnt_q, retire_cnt_d;
    logic        illegal_q, illegal_d;
    logic        timeout_q, timeout_d;

    logic        op_illegal;

    assign op_illegal = (bus.instr[15:12] == 4'b1100) ||
                        (bus.instr[15:12] == 4'b1101) ||
                        (bus.instr[15:12] == 4'b1110);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            opcode_q     <= 4'h0;
            wait_cnt_q   <= 8'h00;
            retire_cnt_q <= 16'h0000;
            illegal_q    <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            opcode_q     <= opcode_d;
            wait_cnt_q   <= wait_cnt_d;
            retire_cnt_q <= retire_cnt_d;
            illegal_q    <= illegal_d;
            timeout_q    <= timeout_d;
        end
    end

    // Next-state logic; event flags default low so each pulses one cycle
    always_comb begin
        state_d      = state_q;
        opcode_d     = opcode_q;
        wait_cnt_d   = wait_cnt_q;
        retire_cnt_d = retire_cnt_q;
        illegal_d    = 1'b0;
        timeout_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.instr_valid) begin
                    opcode_d = bus.instr[15:12];
                    if (op_illegal) illegal_d = 1'b1;
                    else            state_d   = ISSUE;
                end
            end
            ISSUE: begin
                state_d    = WAIT;
                wait_cnt_d = 8'h00;
            end
            WAIT: begin
                // Completion wins over timeout on the last permitted cycle
                if (bus.unit_done) begin
                    state_d      = RETIRE;
                    retire_cnt_d = retire_cnt_q + 16'd1;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            RETIRE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.instr_ready  = (state_q == IDLE);
    assign bus.busy         = (state_q != IDLE);
    assign bus.dec_enable   = (state_q == ISSUE);
    assign bus.dec_opcode   = opcode_q;
    assign bus.retire       = (state_q == RETIRE);
    assign bus.illegal      = illegal_q;
    assign bus.timeout      = timeout_q;
    assign bus.retire_count = retire_cnt_q;

endmodule
